// File: rtl/dma_burst_packetizer_pkg.sv
// Shared types and helpers for the DMA burst packetizer.
// Zero-padding of short final bursts is enabled by DMA_BURST_PACKETIZER_PAD_EN.
package dma_burst_packetizer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PASS,
      PAD
   } state_t;

   function automatic logic [31:0] clamp_burst_len(input logic [31:0] len,
                                                   input logic [31:0] max_len);
      if (len == '0) return 32'd1;
      if (len > max_len) return max_len;
      return len;
   endfunction

endpackage

// File: rtl/dma_burst_packetizer_axis_reg_slice.sv
// One-deep registered ready/valid stage; accepts a new word whenever the
// held word is absent or leaving in the same cycle.
module axis_reg_slice #(
   parameter int unsigned WIDTH = 128
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             s_valid_i,
   output logic             s_ready_o,
   input  logic [WIDTH-1:0] s_data_i,
   input  logic             s_last_i,
   output logic             m_valid_o,
   input  logic             m_ready_i,
   output logic [WIDTH-1:0] m_data_o,
   output logic             m_last_o
);

   logic             valid_q;
   logic [WIDTH-1:0] data_q;
   logic             last_q;

   assign s_ready_o = !valid_q || m_ready_i;
   assign m_valid_o = valid_q;
   assign m_data_o  = data_q;
   assign m_last_o  = last_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else if (s_valid_i && s_ready_o) begin
         valid_q <= 1'b1;
         data_q  <= s_data_i;
         last_q  <= s_last_i;
      end else if (m_ready_i) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end
   end

endmodule

// File: rtl/dma_burst_packetizer.sv
// Segments a readout stream into burst_len-word bursts with last framing.
// Define DMA_BURST_PACKETIZER_PAD_EN to zero-pad the final short burst.
module dma_burst_packetizer
   import dma_burst_packetizer_pkg::*;
#(
   parameter int unsigned AXI_MM_WIDTH    = 128,
   parameter int unsigned MAX_BURST_WORDS = 256,
   parameter int unsigned BURST_WIDTH     = $clog2(MAX_BURST_WORDS) + 1
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    burst_config_valid_i,
   output logic                    burst_config_ready_o,
   input  logic [BURST_WIDTH-1:0]  burst_config_data_i,
   input  logic                    data_in_valid_i,
   output logic                    data_in_ready_o,
   input  logic [AXI_MM_WIDTH-1:0] data_in_data_i,
   input  logic                    data_in_last_i,
   output logic                    data_out_valid_o,
   input  logic                    data_out_ready_i,
   output logic [AXI_MM_WIDTH-1:0] data_out_data_o,
   output logic                    data_out_last_o,
   output logic [31:0]             burst_count_o,
   output logic                    busy_o
);

   state_t                  state_q;
   logic                    en_q;
   logic [BURST_WIDTH-1:0]  burst_len_q;
   logic [BURST_WIDTH-1:0]  word_idx_q;
   logic [31:0]             burst_count_q;
   logic                    busy_q;

   logic                    cfg_fire, acc, boundary, sl_valid, sl_ready, sl_last, final_out;
   logic [BURST_WIDTH-1:0]  len_cfg, len_cur, idx_cur;
   logic [31:0]             cnt_base;
   logic [AXI_MM_WIDTH-1:0] sl_data;
`ifdef DMA_BURST_PACKETIZER_PAD_EN
   logic                    pad_fire;
`endif

   always_comb begin
      burst_config_ready_o = en_q && (state_q == IDLE);
      data_in_ready_o      = en_q && (state_q != PAD) && sl_ready;
      cfg_fire  = burst_config_valid_i && burst_config_ready_o;
      acc       = data_in_valid_i && data_in_ready_o;
      len_cfg   = BURST_WIDTH'(clamp_burst_len(32'(burst_config_data_i), 32'(MAX_BURST_WORDS)));
      // A config accepted alongside the first word already governs that word.
      len_cur   = cfg_fire ? len_cfg : burst_len_q;
      idx_cur   = (state_q == IDLE) ? '0 : word_idx_q;
      cnt_base  = (state_q == IDLE) ? '0 : burst_count_q;
      boundary  = (idx_cur == len_cur - 1'b1);
      final_out = data_out_valid_o && data_out_ready_i && data_out_last_o && (state_q == IDLE);
`ifdef DMA_BURST_PACKETIZER_PAD_EN
      pad_fire  = (state_q == PAD) && sl_ready;
      sl_valid  = acc || pad_fire;
      sl_data   = (state_q == PAD) ? '0 : data_in_data_i;
      sl_last   = boundary;
`else
      sl_valid  = acc;
      sl_data   = data_in_data_i;
      sl_last   = boundary || data_in_last_i;
`endif
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q       <= IDLE;
         en_q          <= 1'b0;
         burst_len_q   <= BURST_WIDTH'(MAX_BURST_WORDS);
         word_idx_q    <= '0;
         burst_count_q <= '0;
         busy_q        <= 1'b0;
      end else begin
         en_q <= 1'b1;
         if (final_out) busy_q <= 1'b0;
         if (cfg_fire) burst_len_q <= len_cfg;
         if (acc) begin
            busy_q <= 1'b1;
            if (boundary) begin
               word_idx_q    <= '0;
               burst_count_q <= cnt_base + 32'd1;
               state_q       <= data_in_last_i ? IDLE : PASS;
            end else if (data_in_last_i) begin
`ifdef DMA_BURST_PACKETIZER_PAD_EN
               word_idx_q    <= idx_cur + 1'b1;
               burst_count_q <= cnt_base;
               state_q       <= PAD;
`else
               word_idx_q    <= '0;
               burst_count_q <= cnt_base + 32'd1;
               state_q       <= IDLE;
`endif
            end else begin
               word_idx_q    <= idx_cur + 1'b1;
               burst_count_q <= cnt_base;
               state_q       <= PASS;
            end
         end
`ifdef DMA_BURST_PACKETIZER_PAD_EN
         else if (pad_fire) begin
            if (boundary) begin
               word_idx_q    <= '0;
               burst_count_q <= burst_count_q + 32'd1;
               state_q       <= IDLE;
            end else begin
               word_idx_q    <= word_idx_q + 1'b1;
            end
         end
`endif
      end
   end

   assign burst_count_o = burst_count_q;
   assign busy_o        = busy_q;

   axis_reg_slice #(.WIDTH(AXI_MM_WIDTH)) u_out_slice (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .s_valid_i (sl_valid),
      .s_ready_o (sl_ready),
      .s_data_i  (sl_data),
      .s_last_i  (sl_last),
      .m_valid_o (data_out_valid_o),
      .m_ready_i (data_out_ready_i),
      .m_data_o  (data_out_data_o),
      .m_last_o  (data_out_last_o)
   );

endmodule
